serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It reuses one internal 1-bit full-adder slice (sum = a^b^c, carry = majority) over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands. It is the sequenced, area-minimal counterpart of the combinational ripple-carry adder in the arithmetic lab set. Operation uses a start/busy/done handshake so a top-level FSM or bench can drive it.

---
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first,
// with a start/busy/done handshake. Define SERIAL_ADDER_SUB_EN to add a sub port (a - b).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  // The single full-adder slice shared by every bit position.
  always_comb begin
    bit_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
    bit_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    acc_next  = {bit_sum, acc_reg[WIDTH-1:1]};
  end

  // Subtraction reuses the adder as a + ~b + 1; cin is ignored in that mode.
  always_comb begin
    load_b = b;
    load_c = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      load_b = ~b;
      load_c = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          acc_reg   <= acc_next;
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= bit_carry;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            sum       <= acc_next;
            cout      <= bit_carry;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE otherwise falls back to IDLE.
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= load_b;
            carry_reg <= load_c;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed plan cases plus random
// operands against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;
  localparam int BOUND = 3 * W + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Reference: plain (W+1)-bit arithmetic; subtraction as a + ~b + 1.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W-1:0] ny;
    ny = ~y;
    if (s) model = {1'b0, x} + {1'b0, ny} + (W+1)'(1);
    else   model = {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // Issues one operation from a point away from the clock edge, then follows it
  // to completion. Returns with time at #1 after the edge that raised done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input bit hold_start, input string name);
    logic [W:0]   exp;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           cycles;
    exp       = model(ta, tb_v, tc, ts);
    held_sum  = sum;
    held_cout = cout;
    start = 1'b1; a = ta; b = tb_v; cin = tc; sub = ts;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    // Scramble inputs: the result must come from the captured operands.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < BOUND) begin
      n_cmp++;
      if (busy !== 1'b1 || sum !== held_sum || cout !== held_cout) begin
        n_bad++;
        $display("FAIL %s run cycle %0d: busy=%b sum=%h cout=%b required busy=1 sum=%h cout=%b",
                 name, cycles, busy, sum, cout, held_sum, held_cout);
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    n_cmp++;
    if (cycles !== W) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, cycles, W);
    end
    n_cmp++;
    if (sum !== exp[W-1:0] || cout !== exp[W] || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s result: sum=%h cout=%b busy=%b required sum=%h cout=%b busy=0",
               name, sum, cout, busy, exp[W-1:0], exp[W]);
    end
    $display("op %s a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b (%0d cycles)",
             name, ta, tb_v, tc, ts, sum, cout, cycles);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b required all 0", busy, done, sum, cout);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, "add_0f_01");
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse_width: done=%b busy=%b required 0/0", done, busy);
    end
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "add_ff_01");
    @(posedge clk); #1;
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "add_cin_only");
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, "start_held");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, "b2b_first");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, "b2b_second");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b required all 0", busy, done, sum, cout);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_done cycle %0d: done=%b busy=%b required 0/0", i, done, busy);
      end
    end
    run_op(8'h55, 8'h66, 1'b1, 1'b0, 1'b0, "after_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", i));
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    run_op(8'd5, 8'd3, 1'b0, 1'b1, 1'b0, "sub_5_3");
    @(posedge clk); #1;
    run_op(8'd3, 8'd5, 1'b1, 1'b1, 1'b0, "sub_3_5");
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, $sformatf("rsub%0d", i));
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
